data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: word RAM behind a 2-entry store buffer with per-byte load forwarding
module data_memory_responder #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]           req_wdata_i,
    input  logic [3:0]            req_be_i,
    output logic                  rsp_valid_o,
    output logic [31:0]           rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic [1:0]            wbuf_count_o,
    output logic                  idle_o
);
    localparam int AW = ADDR_WIDTH - 2;
    localparam int DEPTH = 2 ** AW;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] b_addr [2];
    logic [31:0]   b_data [2];
    logic [3:0]    b_be [2];
    logic [1:0]    count;
    logic [AW-1:0] idx;
    logic          accept, err, load, store, drain, wr;
    logic [3:0]    fwd_mask, fwd_mask_q;
    logic [31:0]   fwd_data, fwd_data_q, rd_q;
    logic          rsp_valid, rsp_err, rsp_load;
    assign idx = req_addr_i[ADDR_WIDTH-1:2];
    assign req_ready_o = count != 2'd2;
    assign accept = req_valid_i && req_ready_o;
    assign err = accept && req_be_i == 4'd0;
    assign load = accept && !req_we_i && !err;
    assign store = accept && req_we_i && !err;
    assign drain = count != 2'd0 && !load;
    assign wr = count[0] && !drain;
    assign rsp_valid_o = rsp_valid;
    assign rsp_err_o = rsp_err;
    assign wbuf_count_o = count;
    assign idle_o = count == 2'd0 && !rsp_valid;
    // later entries are newer, so they override older ones lane by lane
    always_comb begin
        fwd_mask = '0;
        fwd_data = '0;
        for (int e = 0; e < 2; e++)
            for (int n = 0; n < 4; n++)
                if (int'(count) > e && b_addr[e] == idx && b_be[e][n]) begin
                    fwd_mask[n] = 1'b1;
                    fwd_data[8*n+:8] = b_data[e][8*n+:8];
                end
    end
    always_comb begin
        rsp_rdata_o = '0;
        for (int n = 0; n < 4; n++)
            rsp_rdata_o[8*n+:8] = rsp_load ? (fwd_mask_q[n] ? fwd_data_q[8*n+:8] : rd_q[8*n+:8]) : 8'd0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rsp_valid <= 1'b0;
            rsp_err <= 1'b0;
            rsp_load <= 1'b0;
            fwd_mask_q <= '0;
            fwd_data_q <= '0;
        end else begin
            count <= count + {1'b0, store} - {1'b0, drain};
            rsp_valid <= accept;
            rsp_err <= err;
            rsp_load <= load;
            if (load) begin
                fwd_mask_q <= fwd_mask;
                fwd_data_q <= fwd_data;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (drain) begin
            b_addr[0] <= b_addr[1];
            b_data[0] <= b_data[1];
            b_be[0] <= b_be[1];
        end
        if (store) begin
            b_addr[wr] <= idx;
            b_data[wr] <= req_wdata_i;
            b_be[wr] <= req_be_i;
        end
    end
    always_ff @(posedge clk) begin
        if (drain)
            for (int n = 0; n < 4; n++)
                if (b_be[0][n]) mem[b_addr[0]][8*n+:8] <= b_data[0][8*n+:8];
        rd_q <= mem[idx];
    end
endmodule
